// File: rtl/median_pkg.sv
// median_pkg: shared defaults, state encoding and counter sizing for the median filter
package median_pkg;
    localparam int PIX_W_DEF = 8;
    typedef enum logic {FILL, RUN} state_t;
    function automatic int cnt_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/median9.sv
// median9: combinational 9-input median via a 19-element compare-exchange network
module median9 import median_pkg::*; #(
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic [9*PIX_W-1:0] win,
    output logic [PIX_W-1:0]   med
);
    logic [PIX_W-1:0] v [9];
    function automatic logic [2*PIX_W-1:0] cx(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
        return a > b ? {b, a} : {a, b};
    endfunction
    always_comb begin
        {v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7], v[8]} = win;
        {v[1], v[2]} = cx(v[1], v[2]);
        {v[4], v[5]} = cx(v[4], v[5]);
        {v[7], v[8]} = cx(v[7], v[8]);
        {v[0], v[1]} = cx(v[0], v[1]);
        {v[3], v[4]} = cx(v[3], v[4]);
        {v[6], v[7]} = cx(v[6], v[7]);
        {v[1], v[2]} = cx(v[1], v[2]);
        {v[4], v[5]} = cx(v[4], v[5]);
        {v[7], v[8]} = cx(v[7], v[8]);
        {v[0], v[3]} = cx(v[0], v[3]);
        {v[5], v[8]} = cx(v[5], v[8]);
        {v[4], v[7]} = cx(v[4], v[7]);
        {v[3], v[6]} = cx(v[3], v[6]);
        {v[1], v[4]} = cx(v[1], v[4]);
        {v[2], v[5]} = cx(v[2], v[5]);
        {v[4], v[7]} = cx(v[4], v[7]);
        {v[4], v[2]} = cx(v[4], v[2]);
        {v[6], v[4]} = cx(v[6], v[4]);
        {v[4], v[2]} = cx(v[4], v[2]);
        med = v[4];
    end
endmodule

// File: rtl/median3x3_stream.sv
// median3x3_stream: raster-order 3x3 median filter with two line buffers and registered output
module median3x3_stream import median_pkg::*; #(
    parameter int PIX_W = PIX_W_DEF,
    parameter int IMG_W = 100,
    parameter int IMG_H = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_data,
    input  logic             s_sof,
    input  logic             bypass,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_data,
    output logic             m_eol,
    output logic             m_last
);
    localparam int CW = cnt_w(IMG_W);
    localparam int RW = cnt_w(IMG_H);
    localparam logic [CW-1:0] CMAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] RMAX = RW'(IMG_H - 1);
    logic [CW-1:0] col, ecol, ncol;
    logic [RW-1:0] row, erow, nrow;
    state_t state, state_nx;
    logic [PIX_W-1:0] lb0 [IMG_W];
    logic [PIX_W-1:0] lb1 [IMG_W];
    logic [PIX_W-1:0] w [3][3];
    logic [PIX_W-1:0] top_px, mid_px, med;
    logic [9*PIX_W-1:0] win;
    logic xfer, emit;
    assign s_ready = !m_valid || m_ready;
    assign xfer = s_valid && s_ready;
    // a start-of-frame pixel is processed as position (0,0) regardless of the counters
    always_comb begin
        ecol = s_sof ? '0 : col;
        erow = s_sof ? '0 : row;
        ncol = ecol == CMAX ? '0 : ecol + 1'b1;
        nrow = ecol != CMAX ? erow : erow == RMAX ? '0 : erow + 1'b1;
        top_px = lb1[ecol];
        mid_px = lb0[ecol];
        win = {w[0][1], w[0][2], top_px, w[1][1], w[1][2], mid_px, w[2][1], w[2][2], s_data};
    end
    median9 #(.PIX_W(PIX_W)) u_med (.win(win), .med(med));
    always_ff @(posedge clk)
        state <= rst ? FILL : state_nx;
    always_comb
        state_nx = xfer ? (nrow >= RW'(2) ? RUN : FILL) : state;
    always_comb
        emit = xfer && !s_sof && state == RUN && col >= CW'(2);
    always_ff @(posedge clk)
        if (xfer) begin
            lb1[ecol] <= lb0[ecol];
            lb0[ecol] <= s_data;
        end
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
            w <= '{default: '0};
            m_valid <= 1'b0;
            m_data <= '0;
            m_eol <= 1'b0;
            m_last <= 1'b0;
        end else begin
            if (xfer) begin
                col <= ncol;
                row <= nrow;
                w[0] <= '{w[0][1], w[0][2], top_px};
                w[1] <= '{w[1][1], w[1][2], mid_px};
                w[2] <= '{w[2][1], w[2][2], s_data};
            end
            if (emit) begin
                m_valid <= 1'b1;
                m_data <= bypass ? w[1][2] : med;
                m_eol <= col == CMAX;
                m_last <= col == CMAX && row == RMAX;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_median3x3_stream.sv
// tb_median3x3_stream: scoreboard bench for the streaming median filter on 5x5 and 100x100 frames
module tb_median3x3_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic big = 1'b0;
    logic s_valid = 1'b0, s_sof = 1'b0, bypass = 1'b0, m_ready = 1'b1;
    logic [7:0] s_data = '0;
    logic r5, r100, v5, v100, e5, e100, l5, l100;
    logic [7:0] d5, d100;
    logic s_ready, m_valid, m_eol, m_last;
    logic [7:0] m_data;
    assign s_ready = big ? r100 : r5;
    assign m_valid = big ? v100 : v5;
    assign m_data  = big ? d100 : d5;
    assign m_eol   = big ? e100 : e5;
    assign m_last  = big ? l100 : l5;

    median3x3_stream #(.PIX_W(8), .IMG_W(5), .IMG_H(5)) u5 (
        .clk(clk), .rst(rst), .s_valid(s_valid && !big), .s_ready(r5), .s_data(s_data),
        .s_sof(s_sof), .bypass(bypass), .m_valid(v5), .m_ready(m_ready), .m_data(d5),
        .m_eol(e5), .m_last(l5));
    median3x3_stream #(.PIX_W(8), .IMG_W(100), .IMG_H(100)) u100 (
        .clk(clk), .rst(rst), .s_valid(s_valid && big), .s_ready(r100), .s_data(s_data),
        .s_sof(s_sof), .bypass(bypass), .m_valid(v100), .m_ready(m_ready), .m_data(d100),
        .m_eol(e100), .m_last(l100));

    typedef struct packed {logic [7:0] d; logic eol; logic last;} out_t;
    out_t exp_q[$], got_q[$];
    int checks = 0, errors = 0;
    int W = 5, H = 5, pr = 0, pc = 0, mode = 0;
    bit gaps = 1'b0;
    int img [100][100];
    int s1 [9] = '{6, 7, 8, 11, 12, 13, 16, 17, 18};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, req, $time);
        end
    endtask

    function automatic int med_of(input int r, input int c);
        int a [9];
        int t;
        for (int i = 0; i < 9; i++) a[i] = img[r - 2 + i / 3][c - 2 + i % 3];
        for (int i = 1; i < 9; i++)
            for (int j = i; j > 0 && a[j-1] > a[j]; j--) begin
                t = a[j]; a[j] = a[j-1]; a[j-1] = t;
            end
        return a[4];
    endfunction

    task automatic model(input int d, input bit sof, input bit byp);
        out_t e;
        if (sof) begin pr = 0; pc = 0; end
        img[pr][pc] = d;
        if (pr >= 2 && pc >= 2) begin
            e.d = 8'(byp ? img[pr-1][pc-1] : med_of(pr, pc));
            e.eol = pc == W - 1;
            e.last = pc == W - 1 && pr == H - 1;
            exp_q.push_back(e);
        end
        if (pc == W - 1) begin pc = 0; pr = pr == H - 1 ? 0 : pr + 1; end
        else pc++;
    endtask

    task automatic send(input int d, input bit sof, input bit byp);
        int n = 0;
        bit acc;
        if (gaps && $urandom_range(0, 1) == 1) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
        end
        s_valid = 1'b1; s_data = 8'(d); s_sof = sof; bypass = byp;
        do begin
            @(negedge clk); acc = s_ready;
            @(posedge clk); #1; n++;
        end while (!acc && n < 1000);
        if (!acc) check("send_timeout", 0, 1);
        else model(d, sof, byp);
        s_valid = 1'b0; s_sof = 1'b0;
    endtask

    task automatic frame(input int kind, input bit sof1, input bit byp, input int npix);
        int r, c, d;
        for (int i = 0; i < npix; i++) begin
            r = i / W; c = i % W;
            d = kind == 0 ? i % 256 : kind == 1 ? (((r == 10 && c == 10) || (r == 50 && c == 73)) ? 255 : 50)
                                                : int'($urandom_range(0, 255));
            send(d, sof1 && i == 0, byp);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50000) begin @(posedge clk); n++; end
        repeat (5) @(posedge clk);
        #1;
        check("drain_left", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete(); got_q.delete();
        pr = 0; pc = 0;
    endtask

    task automatic check_s1(input string tag);
        check({tag, "_count"}, got_q.size(), 9);
        for (int i = 0; i < got_q.size() && i < 9; i++) check({tag, "_val"}, got_q[i].d, s1[i]);
    endtask

    always @(posedge clk) begin
        #1;
        m_ready = mode == 1 ? ($urandom_range(0, 99) < 40) : mode != 2;
    end

    bit stalled = 1'b0;
    out_t held, e;
    always @(negedge clk) begin
        if (rst) stalled = 1'b0;
        else begin
            if (stalled) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, held.d);
                check("hold_flags", {m_eol, m_last}, {held.eol, held.last});
            end
            if (m_valid && m_ready) begin
                got_q.push_back({m_data, m_eol, m_last});
                if (exp_q.size() == 0) check("spurious_out", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("data", m_data, e.d);
                    check("eol", m_eol, e.eol);
                    check("last", m_last, e.last);
                end
            end
            stalled = m_valid && !m_ready;
            held = {m_data, m_eol, m_last};
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_eol", m_eol, 0);
        check("rst_m_last", m_last, 0);
        check("rst_s_ready", s_ready, 1);
        @(posedge clk); #1;

        frame(0, 1, 0, 25);
        drain();
        check_s1("ramp");
        for (int i = 0; i < got_q.size() && i < 9; i++) begin
            check("ramp_eol", got_q[i].eol, i % 3 == 2);
            check("ramp_last", got_q[i].last, i == 8);
        end
        got_q.delete();

        big = 1'b1; W = 100; H = 100;
        frame(1, 1, 0, 10000);
        drain();
        check("salt_count", got_q.size(), 9604);
        n = 0;
        foreach (got_q[i]) if (got_q[i].d != 8'd50) n++;
        check("salt_non50", n, 0);
        got_q.delete();
        frame(1, 1, 1, 10000);
        drain();
        check("byp_count", got_q.size(), 9604);
        n = 0;
        foreach (got_q[i]) if (got_q[i].d == 8'd255) n++;
        check("byp_n255", n, 2);
        if (got_q.size() == 9604) begin
            check("byp_10_10", got_q[891].d, 255);
            check("byp_50_73", got_q[4874].d, 255);
        end
        got_q.delete();
        big = 1'b0; W = 5; H = 5;

        mode = 1; gaps = 1'b1;
        frame(0, 1, 0, 25);
        repeat (3) frame(2, 1, 0, 25);
        drain();
        mode = 0; gaps = 1'b0;
        check("bp_total", got_q.size(), 36);
        for (int i = 0; i < got_q.size() && i < 9; i++) check("bp_val", got_q[i].d, s1[i]);
        got_q.delete();

        frame(0, 1, 0, 25);
        frame(2, 1, 0, 25);
        frame(0, 1, 0, 25);
        drain();
        check("b2b_count", got_q.size(), 27);
        foreach (got_q[i]) check("b2b_last", got_q[i].last, i % 9 == 8);
        got_q.delete();

        mode = 2;
        frame(0, 1, 0, 13);
        do_reset();
        mode = 0;
        @(negedge clk);
        check("abort_m_valid", m_valid, 0);
        @(posedge clk); #1;
        frame(0, 1, 0, 25);
        drain();
        check_s1("after_rst");
        got_q.delete();

        frame(0, 1, 0, 7);
        frame(0, 1, 0, 25);
        drain();
        check_s1("resync");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
